// File: rtl/mips_defs_pkg.sv
// Shared MIPS core definitions: default widths, NOP encoding, reset PC and the fetch-entry record.
package mips_defs_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] INST_NOP = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer storage: DEPTH x W entries with wrapping pointers, occupancy count and a
// synchronous clear that wins over push and pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop & ~empty;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !clear && !rst) mem[wr_ptr] <= din;
  end

  // The credit scheme upstream guarantees a free slot for every accepted return.
  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !do_pop && !clear && count == CW'(DEPTH)));
endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch: issues PC to the synchronous ROM, pairs returns with their PC and buffers
// them for ID. Optional IF_QUEUE_BYPASS_EN presents a return straight to ID when the queue is empty.
module if_fetch_queue
  import mips_defs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = ADDR_W,
  parameter int DW    = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_i,
  input  logic          ce_i,
  input  logic          flush_i,
  output logic [AW-1:0] rom_addr_o,
  output logic          rom_ce_o,
  input  logic [DW-1:0] rom_data_i,
  input  logic          id_stall_i,
  output logic          id_valid_o,
  output logic [AW-1:0] id_pc_o,
  output logic [DW-1:0] id_inst_o,
  output logic          fetch_stall_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
  } entry_t;

  logic          pending;
  logic [AW-1:0] pend_pc;
  logic [CW-1:0] count;
  logic [CW:0]   credit;
  logic          empty, ret, byp, push, pop;
  entry_t        head, ret_entry;

  // Credit counts in-flight reads; a pop this cycle does not free a slot until next cycle.
  assign credit        = (CW+1)'(count) + (CW+1)'(pending);
  assign fetch_stall_o = (credit >= (CW+1)'(DEPTH));

  assign rom_addr_o = pc_i;
  assign rom_ce_o   = ce_i & ~fetch_stall_o & ~flush_i & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      pend_pc <= AW'(RESET_PC);
    end else begin
      pending <= rom_ce_o;
      if (rom_ce_o) pend_pc <= pc_i;
    end
  end

  assign ret       = pending & ~flush_i;
  assign ret_entry = '{pc: pend_pc, inst: rom_data_i};

`ifdef IF_QUEUE_BYPASS_EN
  assign byp = ret & empty;
`else
  assign byp = 1'b0;
`endif

  // A bypassed word that ID takes this cycle never occupies a slot.
  assign push = ret & ~(byp & ~id_stall_i);
  assign pop  = ~empty & ~id_stall_i & ~flush_i;

  fetch_fifo #(.DEPTH(DEPTH), .W(AW+DW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush_i),
    .push  (push),
    .pop   (pop),
    .din   (ret_entry),
    .dout  (head),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    id_valid_o = 1'b0;
    id_pc_o    = '0;
    id_inst_o  = DW'(INST_NOP);
    if (!rst) begin
      if (byp) begin
        id_valid_o = 1'b1;
        id_pc_o    = ret_entry.pc;
        id_inst_o  = ret_entry.inst;
      end else if (!empty) begin
        id_valid_o = 1'b1;
        id_pc_o    = head.pc;
        id_inst_o  = head.inst;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: PC-register and ROM models plus an in-order scoreboard of issued fetches.
module tb_if_fetch_queue;
  import mips_defs_pkg::*;

`ifdef IF_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1, ce = 1'b0, flush = 1'b0, stall = 1'b0;
  logic [31:0] pc, target = '0, rom_addr, rom_data, id_pc, id_inst;
  logic        rom_ce, id_valid, fetch_stall;
  int          checks = 0, errors = 0;
  fetch_entry_t exp_q[$];

  if_fetch_queue dut (
    .clk(clk), .rst(rst), .pc_i(pc), .ce_i(ce), .flush_i(flush),
    .rom_addr_o(rom_addr), .rom_ce_o(rom_ce), .rom_data_i(rom_data),
    .id_stall_i(stall), .id_valid_o(id_valid), .id_pc_o(id_pc), .id_inst_o(id_inst),
    .fetch_stall_o(fetch_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0] + 16'h1};
  endfunction

  // PC register: redirect on flush, advance only when a fetch was actually issued.
  always @(posedge clk) begin
    if (rst)         pc <= 32'h0;
    else if (flush)  pc <= target;
    else if (rom_ce) pc <= pc + 32'd4;
  end

  always @(posedge clk) if (rom_ce) rom_data <= rom_word(rom_addr);

  // Scoreboard: consume on accepted delivery, record every issue.
  always @(negedge clk) begin : mon
    fetch_entry_t e;
    if (rst || flush) exp_q.delete();
    else begin
      if (id_valid && !stall) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got pc=%h inst=%h, none expected", id_pc, id_inst);
        end else begin
          e = exp_q.pop_front();
          if (id_pc !== e.pc || id_inst !== e.inst) begin
            errors++;
            $display("FAIL sb_order got pc=%h inst=%h want pc=%h inst=%h", id_pc, id_inst, e.pc, e.inst);
          end
        end
      end
      if (rom_ce) exp_q.push_back('{pc: rom_addr, inst: rom_word(rom_addr)});
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; ce = 1'b0; flush = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string name);
    @(posedge clk); #1;
    ce = 1'b0; stall = 1'b0;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain left=%0d want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({id_valid, fetch_stall, rom_ce, id_pc, id_inst} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b st=%b ce=%b pc=%h inst=%h want all 0",
               id_valid, fetch_stall, rom_ce, id_pc, id_inst);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_stream();
    int n = 0;
    @(posedge clk); #1 ce = 1'b1;
    for (int c = 0; c <= LAT; c++) begin
      @(negedge clk);
      checks++;
      if (id_valid !== (c == LAT)) begin
        errors++;
        $display("FAIL stream_latency cycle %0d got valid=%b want %b", c, id_valid, c == LAT);
      end
      if (c == 0) begin
        checks++;
        if (rom_addr !== 32'h0 || rom_ce !== 1'b1) begin
          errors++;
          $display("FAIL stream_issue got addr=%h ce=%b want 0/1", rom_addr, rom_ce);
        end
      end
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (id_valid) n++;
    end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL stream_throughput got %0d valid of 8 want 8", n);
    end
    drain("stream");
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    do_reset();
    stall = 1'b1; ce = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++;
    if (fetch_stall !== 1'b1 || rom_ce !== 1'b0 || dut.u_fifo.count !== 3'd4 ||
        pc !== 32'h10 || id_pc !== 32'h0) begin
      errors++;
      $display("FAIL bp_full got st=%b ce=%b cnt=%0d pc=%h head=%h want 1/0/4/10/0",
               fetch_stall, rom_ce, dut.u_fifo.count, pc, id_pc);
    end
    @(posedge clk); #1 stall = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (rom_ce) seen = 1;
    end
    checks++;
    if (!seen || rom_addr !== 32'h10) begin
      errors++;
      $display("FAIL bp_resume got seen=%b addr=%h want 1/00000010", seen, rom_addr);
    end
    repeat (6) @(posedge clk);
    drain("bp");
  endtask

  task automatic test_flush();
    bit seen = 0;
    do_reset();
    stall = 1'b1; ce = 1'b1;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1; target = 32'h100;
    @(negedge clk);
    checks++;
    if (fetch_stall !== 1'b1 || dut.u_fifo.count !== 3'd3) begin
      errors++;
      $display("FAIL flush_setup got st=%b cnt=%0d want 1/3", fetch_stall, dut.u_fifo.count);
    end
    @(posedge clk); #1 flush = 1'b0; stall = 1'b0;
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b0 || id_inst !== 32'h0) begin
      errors++;
      $display("FAIL flush_clear got v=%b inst=%h want 0/0", id_valid, id_inst);
    end
    for (int i = 0; i < 8 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      if (id_valid) seen = 1;
    end
    checks++;
    if (!seen || id_pc !== 32'h100) begin
      errors++;
      $display("FAIL flush_target got seen=%b pc=%h want 1/00000100", seen, id_pc);
    end
    drain("flush");
  endtask

  task automatic test_push_pop();
    do_reset();
    stall = 1'b1; ce = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.u_fifo.count !== 3'd2 || id_pc !== 32'h0) begin
      errors++;
      $display("FAIL pp_before got cnt=%0d head=%h want 2/0", dut.u_fifo.count, id_pc);
    end
    @(posedge clk); #1 stall = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.u_fifo.count !== 3'd2 || id_pc !== 32'h4 || id_inst !== rom_word(32'h4)) begin
      errors++;
      $display("FAIL pp_after got cnt=%0d head=%h inst=%h want 2/4/%h",
               dut.u_fifo.count, id_pc, id_inst, rom_word(32'h4));
    end
    drain("pp");
  endtask

  task automatic test_reset_mid();
    do_reset();
    ce = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; ce = 1'b0;
    @(negedge clk);
    checks++;
    if ({id_valid, fetch_stall, rom_ce, id_pc, id_inst} !== '0) begin
      errors++;
      $display("FAIL rstmid_during got v=%b st=%b ce=%b pc=%h inst=%h want all 0",
               id_valid, fetch_stall, rom_ce, id_pc, id_inst);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({id_valid, fetch_stall, id_pc, id_inst} !== '0) begin
        errors++;
        $display("FAIL rstmid_after cycle %0d got v=%b st=%b pc=%h inst=%h want all 0",
                 i, id_valid, fetch_stall, id_pc, id_inst);
      end
    end
    exp_q.delete();
  endtask

`ifdef IF_QUEUE_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    ce = 1'b1;
    @(posedge clk); #1 ce = 1'b0; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== rom_word(32'h0)) begin
        errors++;
        $display("FAIL bypass_n%0d got v=%b pc=%h inst=%h want 1/0/%h",
                 i + 1, id_valid, id_pc, id_inst, rom_word(32'h0));
      end
      if (i == 0) @(posedge clk);
    end
    drain("bypass");
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_push_pop();
    test_reset_mid();
`ifdef IF_QUEUE_BYPASS_EN
    test_bypass();
`endif
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
